argmax_seq: RTL and testbench
=============================

# argmax_seq

Parametrised sequential argmax for the classifier output stage. Accepts one vector of `NUM_CLASSES` signed logits through a valid/ready handshake and captures it. Scans the vector one element per cycle and returns the winning class index, the winning logit value and a tie flag. It replaces the fixed 3-class combinational argmax and sits between the final readout layer and the result interface.

## Interface
- `DATA_WIDTH`, 32: width of one signed logit.
- `NUM_CLASSES`, 3: number of logits per vector; legal range ≥ 2.
- `IDX_WIDTH`, `$clog2(NUM_CLASSES)`: width of the class index. Derived; not to be overridden.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: input vector valid.
- `i_ready` out 1: block can accept a vector.
- `i_logits` in `NUM_CLASSES*DATA_WIDTH`: signed logits; element k is bits `[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]`.
- `o_valid` out 1: result valid.
- `o_ready` in 1: downstream accepts the result.
- `o_class` out `IDX_WIDTH`: index of the maximum logit.
- `o_max_logit` out `DATA_WIDTH`: signed value of the maximum logit.
- `o_tie` out 1: at least one other element equals the maximum.

## Operation
- FSM states: IDLE, SCAN, DONE.
- `i_ready` = (state == IDLE). It is decoded from state, so it goes high immediately when reset asserts.
- IDLE:
  - On `i_valid && i_ready`, register the full `i_logits` vector.
  - Initialise `best_val` = logit[0], `best_idx` = 0, `tie` = 0, `k` = 1.
  - Go to SCAN.
  - `i_logits` need not be held stable after acceptance.
- SCAN, one element per cycle, signed compare of the captured logit[k] against `best_val`:
  - logit[k] > `best_val`: set `best_val` = logit[k], `best_idx` = k, `tie` = 0.
  - logit[k] == `best_val`: keep `best_val`/`best_idx`, set `tie` = 1. Lowest index wins ties, consistent with the previous `>=` priority.
  - logit[k] < `best_val`: no change.
  - If k == `NUM_CLASSES`-1, load the final values into `o_class`, `o_max_logit`, `o_tie`, set `o_valid` = 1 and go to DONE. Otherwise k = k+1.
  - The final-element compare result must be included in the registered outputs (no off-by-one).
- DONE:
  - `o_valid`, `o_class`, `o_max_logit`, `o_tie` are held stable until `o_valid && o_ready`.
  - On handshake, clear `o_valid` and go to IDLE.
  - `o_ready` may be asserted or deasserted arbitrarily. Holding it low stalls indefinitely with outputs unchanged.
- `i_valid` is ignored outside IDLE; no vector is dropped silently, because `i_ready` = 0 there.
- `o_ready` is ignored outside DONE.
- Reset mid-SCAN or mid-DONE returns the block to IDLE, discards the partial result and clears `o_valid` asynchronously.
- All comparisons are signed two's complement at full `DATA_WIDTH`.
  - The most negative value is a legal logit.
  - An all-equal vector gives `o_class` = 0 and `o_tie` = 1.

## Timing
- Reset values:
  - state = IDLE, so `i_ready` = 1.
  - `o_valid` = 0, `o_class` = 0, `o_max_logit` = 0, `o_tie` = 0.
  - Internal capture registers, `k`, `best_*` and `tie` = 0.
- Let the input acceptance edge be edge E.
- SCAN occupies edges E+1 … E+`NUM_CLASSES`-1. `o_valid` rises after edge E+`NUM_CLASSES`-1, giving latency `NUM_CLASSES`-1 cycles.
  - `NUM_CLASSES` = 2: `o_valid` high one cycle after acceptance.
- Output handshake at edge H: IDLE after H, `i_ready` high in cycle H+1, earliest next acceptance at edge H+1.
- Maximum throughput with `o_ready` tied high: one vector per `NUM_CLASSES`+1 cycles.
- No combinational path from `i_valid` or `o_ready` to any output.

## Test plan
- Reset, then idle: `o_valid` = 0, `i_ready` = 1, `o_class` = 0, `o_max_logit` = 0, `o_tie` = 0.
- `NUM_CLASSES` = 3, logits {0: 5, 1: -3, 2: 12}, `o_ready` = 1 -> `o_class` = 2, `o_max_logit` = 12, `o_tie` = 0. `o_valid` exactly 2 cycles after acceptance, high for 1 cycle.
- Ties, {7, 7, -1} -> `o_class` = 0, `o_tie` = 1.
- Ties, {-4, 9, 9} -> `o_class` = 1, `o_tie` = 1.
- Tie cleared by a later maximum: {3, 3, 8} -> `o_class` = 2, `o_tie` = 0.
- Signed extremes, `NUM_CLASSES` = 8, `DATA_WIDTH` = 16:
  - Stimulus: all 0x8000 except index 5 = 0xFFFF (-1) -> `o_class` = 5, `o_max_logit` = 0xFFFF, `o_tie` = 0. `o_valid` after 7 cycles.
  - Stimulus: all 0x8000 -> `o_class` = 0, `o_tie` = 1.
- Backpressure and reset:
  - `o_ready` low for 10 cycles after `o_valid`: outputs stable, `i_ready` = 0, a new `i_valid` is not accepted.
  - Release `o_ready`: `i_ready` rises the next cycle.
  - Assert `rst_n` low mid-SCAN: `o_valid` = 0, `i_ready` = 1. After release, a fresh vector {1, 2, 0} produces `o_class` = 1.

Source files
------------

// File: rtl/argmax_seq_if.sv
// Handshake bundle for argmax_seq: vector in (valid/ready), result out (valid/ready).
// The slave modport is the argmax block; the master modport is the producer/consumer side.
interface argmax_seq_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 3
);
  localparam int IDX_WIDTH = $clog2(NUM_CLASSES);

  logic                              i_valid;
  logic                              i_ready;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_logits;
  logic                              o_valid;
  logic                              o_ready;
  logic [IDX_WIDTH-1:0]              o_class;
  logic [DATA_WIDTH-1:0]             o_max_logit;
  logic                              o_tie;

  modport master (
    output i_valid, i_logits, o_ready,
    input  i_ready, o_valid, o_class, o_max_logit, o_tie
  );

  modport slave (
    input  i_valid, i_logits, o_ready,
    output i_ready, o_valid, o_class, o_max_logit, o_tie
  );
endinterface

// File: rtl/argmax_seq.sv
// Sequential argmax: captures one vector of signed logits, scans one element per cycle,
// and reports the lowest index holding the maximum plus a tie flag.
module argmax_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  argmax_seq_if.slave bus
);
  localparam int                   IDX_WIDTH = $clog2(NUM_CLASSES);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                       state_reg;
  logic signed [DATA_WIDTH-1:0] in_elem   [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] logit_reg [NUM_CLASSES];
  logic [IDX_WIDTH-1:0]         k_reg;
  logic signed [DATA_WIDTH-1:0] best_val_reg;
  logic [IDX_WIDTH-1:0]         best_idx_reg;
  logic                         tie_reg;

  logic                         o_valid_reg;
  logic [IDX_WIDTH-1:0]         o_class_reg;
  logic [DATA_WIDTH-1:0]        o_max_reg;
  logic                         o_tie_reg;

  logic signed [DATA_WIDTH-1:0] cur_val;
  logic signed [DATA_WIDTH-1:0] best_val_next;
  logic [IDX_WIDTH-1:0]         best_idx_next;
  logic                         tie_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign in_elem[gi] = bus.i_logits[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign cur_val = logit_reg[k_reg];

  // Strict '>' keeps the earliest index on equality; equality only raises the tie flag.
  always_comb begin
    best_val_next = best_val_reg;
    best_idx_next = best_idx_reg;
    tie_next      = tie_reg;
    if (cur_val > best_val_reg) begin
      best_val_next = cur_val;
      best_idx_next = k_reg;
      tie_next      = 1'b0;
    end else if (cur_val == best_val_reg) begin
      tie_next      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        logit_reg[i] <= '0;
      end
      k_reg        <= '0;
      best_val_reg <= '0;
      best_idx_reg <= '0;
      tie_reg      <= 1'b0;
      o_valid_reg  <= 1'b0;
      o_class_reg  <= '0;
      o_max_reg    <= '0;
      o_tie_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.i_valid) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              logit_reg[i] <= in_elem[i];
            end
            best_val_reg <= in_elem[0];
            best_idx_reg <= '0;
            tie_reg      <= 1'b0;
            k_reg        <= IDX_WIDTH'(1);
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          best_val_reg <= best_val_next;
          best_idx_reg <= best_idx_next;
          tie_reg      <= tie_next;
          // The last element's compare feeds the outputs directly, not via best_*_reg.
          if (k_reg == LAST_IDX) begin
            o_class_reg <= best_idx_next;
            o_max_reg   <= best_val_next;
            o_tie_reg   <= tie_next;
            o_valid_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            k_reg <= k_reg + IDX_WIDTH'(1);
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            o_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.i_ready     = (state_reg == IDLE);
  assign bus.o_valid     = o_valid_reg;
  assign bus.o_class     = o_class_reg;
  assign bus.o_max_logit = o_max_reg;
  assign bus.o_tie       = o_tie_reg;
endmodule

// File: tb/tb_argmax_seq.sv
// Bench for argmax_seq: a 3x32 and an 8x16 instance, directed and random vectors
// checked against a whole-vector max/first-index/count model.
module tb_argmax_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  argmax_seq_if #(.DATA_WIDTH(32), .NUM_CLASSES(3)) a_bus ();
  argmax_seq_if #(.DATA_WIDTH(16), .NUM_CLASSES(8)) b_bus ();

  argmax_seq #(.DATA_WIDTH(32), .NUM_CLASSES(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_bus));
  argmax_seq #(.DATA_WIDTH(16), .NUM_CLASSES(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-vector reference: maximum value, first index holding it, tie if it occurs twice+.
  function automatic void model(input logic [255:0] vec, input int n, input int w,
                                output int cls, output logic [63:0] mx, output bit tie);
    longint      v[8];
    longint      best;
    int          cnt;
    logic [63:0] raw, mask;
    mask = (64'd1 << w) - 64'd1;
    for (int k = 0; k < n; k++) begin
      raw  = 64'(vec >> (k*w)) & mask;
      v[k] = raw[w-1] ? longint'(raw) - (longint'(1) << w) : longint'(raw);
    end
    best = v[0];
    for (int k = 1; k < n; k++) if (v[k] > best) best = v[k];
    cls = -1;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      if (v[k] == best) begin
        if (cls < 0) cls = k;
        cnt++;
      end
    end
    tie = (cnt > 1);
    mx  = 64'(best) & mask;
  endfunction

  function automatic logic [95:0] pack3(input int e0, input int e1, input int e2);
    return {32'(e2), 32'(e1), 32'(e0)};
  endfunction

  task automatic wait_a_valid(output int lat);
    lat = 0;
    while (a_bus.o_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_a(input logic [95:0] vec, input string tag);
    int cls, lat;
    logic [63:0] mx;
    bit tie;
    model({160'd0, vec}, 3, 32, cls, mx, tie);
    @(negedge clk);
    check({tag, "_iready"}, 64'(a_bus.i_ready), 64'd1);
    a_bus.i_valid  = 1'b1;
    a_bus.i_logits = vec;
    @(posedge clk); #1;
    a_bus.i_valid  = 1'b0;
    a_bus.i_logits = {$urandom, $urandom, $urandom};
    wait_a_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check({tag, "_class"},   64'(a_bus.o_class), 64'(cls));
    check({tag, "_max"},     64'(a_bus.o_max_logit), mx);
    check({tag, "_tie"},     64'(a_bus.o_tie), 64'(tie));
    $display("txn %s vec=%h class=%0d max=%h tie=%0d lat=%0d", tag, vec,
             a_bus.o_class, a_bus.o_max_logit, a_bus.o_tie, lat);
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, 64'(a_bus.o_valid), 64'd0);
    check({tag, "_ird_back"}, 64'(a_bus.i_ready), 64'd1);
  endtask

  task automatic run_b(input logic [127:0] vec, input string tag);
    int cls, lat;
    logic [63:0] mx;
    bit tie;
    model({128'd0, vec}, 8, 16, cls, mx, tie);
    @(negedge clk);
    check({tag, "_iready"}, 64'(b_bus.i_ready), 64'd1);
    b_bus.i_valid  = 1'b1;
    b_bus.i_logits = vec;
    @(posedge clk); #1;
    b_bus.i_valid  = 1'b0;
    b_bus.i_logits = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (b_bus.o_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd7);
    check({tag, "_class"},   64'(b_bus.o_class), 64'(cls));
    check({tag, "_max"},     64'(b_bus.o_max_logit), mx);
    check({tag, "_tie"},     64'(b_bus.o_tie), 64'(tie));
    $display("txn %s vec=%h class=%0d max=%h tie=%0d lat=%0d", tag, vec,
             b_bus.o_class, b_bus.o_max_logit, b_bus.o_tie, lat);
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, 64'(b_bus.o_valid), 64'd0);
  endtask

  function automatic logic [31:0] rand_a_elem();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($signed($urandom_range(0, 4)) - 2);
      default: return $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7fff_ffff;
    endcase
  endfunction

  function automatic logic [15:0] rand_b_elem();
    case ($urandom_range(0, 2))
      0:       return 16'($urandom);
      1:       return 16'($signed($urandom_range(0, 4)) - 2);
      default: return $urandom_range(0, 1) ? 16'h8000 : 16'hffff;
    endcase
  endfunction

  initial begin
    logic [95:0]  va;
    logic [127:0] vb;
    int           lat;

    rst_n = 1'b0;
    a_bus.i_valid = 1'b0; a_bus.i_logits = '0; a_bus.o_ready = 1'b1;
    b_bus.i_valid = 1'b0; b_bus.i_logits = '0; b_bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ovalid", 64'(a_bus.o_valid), 64'd0);
    check("rst_a_iready", 64'(a_bus.i_ready), 64'd1);
    check("rst_a_class",  64'(a_bus.o_class), 64'd0);
    check("rst_a_max",    64'(a_bus.o_max_logit), 64'd0);
    check("rst_a_tie",    64'(a_bus.o_tie), 64'd0);
    check("rst_b_ovalid", 64'(b_bus.o_valid), 64'd0);
    check("rst_b_iready", 64'(b_bus.i_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed 3-class vectors
    run_a(pack3(5, -3, 12), "a_basic");
    run_a(pack3(7, 7, -1),  "a_tie_first");
    run_a(pack3(-4, 9, 9),  "a_tie_later");
    run_a(pack3(3, 3, 8),   "a_tie_cleared");
    run_a(pack3(32'h8000_0000, 32'h8000_0000, 32'h8000_0000), "a_all_min");

    // Signed extremes on the 8-class instance
    for (int k = 0; k < 8; k++) vb[k*16 +: 16] = (k == 5) ? 16'hffff : 16'h8000;
    run_b(vb, "b_minus_one");
    for (int k = 0; k < 8; k++) vb[k*16 +: 16] = 16'h8000;
    run_b(vb, "b_all_min");

    // Random vectors
    for (int t = 0; t < 20; t++) begin
      va = {rand_a_elem(), rand_a_elem(), rand_a_elem()};
      run_a(va, $sformatf("a_rand%0d", t));
    end
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 8; k++) vb[k*16 +: 16] = rand_b_elem();
      run_b(vb, $sformatf("b_rand%0d", t));
    end

    // Backpressure: result held while o_ready low, competing input refused
    a_bus.o_ready = 1'b0;
    @(negedge clk);
    a_bus.i_valid  = 1'b1;
    a_bus.i_logits = pack3(4, 10, -2);
    @(posedge clk); #1;
    a_bus.i_valid  = 1'b0;
    wait_a_valid(lat);
    check("bp_latency", 64'(lat), 64'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a_bus.i_valid  = 1'b1;
      a_bus.i_logits = pack3(100, 200, 300);
      @(posedge clk); #1;
      check("bp_ovalid", 64'(a_bus.o_valid), 64'd1);
      check("bp_class",  64'(a_bus.o_class), 64'd1);
      check("bp_max",    64'(a_bus.o_max_logit), 64'd10);
      check("bp_tie",    64'(a_bus.o_tie), 64'd0);
      check("bp_iready", 64'(a_bus.i_ready), 64'd0);
    end
    $display("txn bp_hold class=%0d max=%0d", a_bus.o_class, a_bus.o_max_logit);
    @(negedge clk);
    a_bus.o_ready = 1'b1;
    @(posedge clk); #1;
    a_bus.i_valid = 1'b0;
    check("bp_release_ovalid", 64'(a_bus.o_valid), 64'd0);
    check("bp_release_iready", 64'(a_bus.i_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_stray_result", 64'(a_bus.o_valid), 64'd0);

    // Reset in the middle of a scan
    @(negedge clk);
    a_bus.i_valid  = 1'b1;
    a_bus.i_logits = pack3(9, 8, 7);
    @(posedge clk); #1;
    a_bus.i_valid  = 1'b0;
    check("rs_scan_iready", 64'(a_bus.i_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rs_scan_ovalid", 64'(a_bus.o_valid), 64'd0);
    check("rs_scan_iready_async", 64'(a_bus.i_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("rs_scan_no_result", 64'(a_bus.o_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(pack3(1, 2, 0), "a_post_rst");

    // Reset while a result is pending
    a_bus.o_ready = 1'b0;
    @(negedge clk);
    a_bus.i_valid  = 1'b1;
    a_bus.i_logits = pack3(-1, -5, 6);
    @(posedge clk); #1;
    a_bus.i_valid  = 1'b0;
    wait_a_valid(lat);
    check("rd_class", 64'(a_bus.o_class), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rd_ovalid", 64'(a_bus.o_valid), 64'd0);
    check("rd_class_cleared", 64'(a_bus.o_class), 64'd0);
    check("rd_iready", 64'(a_bus.i_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    a_bus.o_ready = 1'b1;
    run_a(pack3(-7, -7, -8), "a_after_done_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
